// File: rtl/game_pkg.sv
// Shared types and constants for the Bulls-and-Cows round sequencing logic.
package game_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    ENTRY = 3'd1,
    CHECK = 3'd2,
    WAIT  = 3'd3,
    SCORE = 3'd4,
    SHOW  = 3'd5,
    WON   = 3'd6,
    LOST  = 3'd7
  } state_t;

  localparam logic [3:0] EMPTY_NIBBLE = 4'hF;
  localparam int         NUM_DIGITS   = 4;
  localparam logic [3:0] WIN_STRIKES  = 4'd4;

endpackage

// File: rtl/digit_entry_buffer.sv
// Guess shift register with occupancy count and a duplicate-digit compare
// against the currently occupied slots (slot 0 holds the newest digit).
module digit_entry_buffer
  import game_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        clr,
  input  logic        push,
  input  logic        pop,
  input  logic        restart,
  input  logic [3:0]  digit,
  output logic [15:0] guess,
  output logic [2:0]  count,
  output logic        dup
);

  // Shift digits in from the right, out to the right on delete, or restart with one digit.
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      guess <= {NUM_DIGITS{EMPTY_NIBBLE}};
      count <= 3'd0;
    end else if (pop) begin
      guess <= {EMPTY_NIBBLE, guess[15:4]};
      count <= count - 3'd1;
    end else if (restart) begin
      guess <= {{(NUM_DIGITS-1){EMPTY_NIBBLE}}, digit};
      count <= 3'd1;
    end else if (push) begin
      guess <= {guess[11:0], digit};
      count <= count + 3'd1;
    end
  end

  // Flag the incoming digit if it matches any slot that already holds a key.
  always_comb begin
    dup = 1'b0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if ((3'(i) < count) && (guess[i*4 +: 4] == digit)) dup = 1'b1;
    end
  end

endmodule

// File: rtl/round_controller.sv
// Sequences one Bulls-and-Cows game: builds a guess, fires the scorer once,
// registers its strike/ball result, counts attempts and declares win or loss.
module round_controller
  import game_pkg::*;
#(
  parameter int MAX_ATTEMPTS = 10,
  parameter int ATT_W        = 4,
  parameter int RESULT_LAT   = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             digit_valid,
  input  logic [3:0]       digit,
  input  logic             del,
  input  logic             new_game,
  input  logic [3:0]       strike,
  input  logic [3:0]       ball,
  output logic [15:0]      guess,
  output logic             check_en,
  output logic [2:0]       digit_count,
  output logic [3:0]       last_strike,
  output logic [3:0]       last_ball,
  output logic [ATT_W-1:0] attempts,
  output logic             dup_err,
  output logic             won,
  output logic             lost
);

  localparam logic [7:0]       WAIT_LAST = 8'((RESULT_LAT > 1) ? (RESULT_LAT - 2) : 0);
  localparam logic [ATT_W-1:0] ATT_MAX   = ATT_W'(MAX_ATTEMPTS);
  localparam logic [ATT_W-1:0] ATT_FINAL = ATT_W'(MAX_ATTEMPTS - 1);

  state_t     state, state_n;
  logic [7:0] wait_cnt;
  logic       legal, dup;
  logic       push, pop, restart, clr, dup_set, score_en;

  assign legal = digit_valid && (digit <= 4'd9);

  digit_entry_buffer u_buf (
    .clk     (clk),
    .rst     (rst),
    .clr     (clr),
    .push    (push),
    .pop     (pop),
    .restart (restart),
    .digit   (digit),
    .guess   (guess),
    .count   (digit_count),
    .dup     (dup)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_n;
  end

  // Next-state and buffer control; new_game overrides every state.
  always_comb begin
    state_n  = state;
    push     = 1'b0;
    pop      = 1'b0;
    restart  = 1'b0;
    clr      = 1'b0;
    dup_set  = 1'b0;
    score_en = 1'b0;
    if (new_game) begin
      state_n = IDLE;
      clr     = 1'b1;
    end else begin
      case (state)
        IDLE: begin
          if (!del && legal) begin
            push    = 1'b1;
            state_n = ENTRY;
          end
        end
        ENTRY: begin
          if (del) begin
            pop = (digit_count != 3'd0);
          end else if (legal) begin
            if (dup) begin
              dup_set = 1'b1;
            end else begin
              push = 1'b1;
              if (digit_count == 3'(NUM_DIGITS - 1)) state_n = CHECK;
            end
          end
        end
        CHECK:   state_n = (RESULT_LAT > 1) ? WAIT : SCORE;
        WAIT:    if (wait_cnt == WAIT_LAST) state_n = SCORE;
        SCORE: begin
          score_en = 1'b1;
          if (strike == WIN_STRIKES)     state_n = WON;
          else if (attempts == ATT_FINAL) state_n = LOST;
          else                            state_n = SHOW;
        end
        SHOW: begin
          if (!del && legal) begin
            restart = 1'b1;
            state_n = ENTRY;
          end
        end
        default: state_n = state;
      endcase
    end
  end

  // Score registers, attempt counter, duplicate pulse and result-latency counter.
  always_ff @(posedge clk) begin
    if (rst || new_game) begin
      last_strike <= 4'd0;
      last_ball   <= 4'd0;
      attempts    <= '0;
      dup_err     <= 1'b0;
      wait_cnt    <= 8'd0;
    end else begin
      dup_err  <= dup_set;
      wait_cnt <= (state == WAIT) ? wait_cnt + 8'd1 : 8'd0;
      if (score_en) begin
        last_strike <= strike;
        last_ball   <= ball;
        if (attempts != ATT_MAX) attempts <= attempts + 1'b1;
      end
    end
  end

  assign check_en = (state == CHECK) && !new_game;
  assign won      = (state == WON);
  assign lost     = (state == LOST);

endmodule

// File: tb/tb_round_controller.sv
// Directed bench for round_controller: instance 0 uses default parameters,
// instance 1 uses MAX_ATTEMPTS=2 and RESULT_LAT=3. Expected guesses are queued
// when the fourth key is driven and popped whenever check_en is seen.
module tb_round_controller;

  logic        clk;
  logic        rst;
  logic        dv  [2];
  logic [3:0]  dg  [2];
  logic        dl  [2];
  logic        ng  [2];
  logic [3:0]  stk [2];
  logic [3:0]  bal [2];
  logic [15:0] gs  [2];
  logic        ce  [2];
  logic [2:0]  cnt [2];
  logic [3:0]  ls  [2];
  logic [3:0]  lb  [2];
  logic [3:0]  att [2];
  logic        dup [2];
  logic        wn  [2];
  logic        lo  [2];

  int errors = 0;
  int checks = 0;
  logic [15:0] exp_q0[$];
  logic [15:0] exp_q1[$];
  logic        prev_ce [2];

  round_controller u_dut0 (
    .clk(clk), .rst(rst), .digit_valid(dv[0]), .digit(dg[0]), .del(dl[0]),
    .new_game(ng[0]), .strike(stk[0]), .ball(bal[0]), .guess(gs[0]),
    .check_en(ce[0]), .digit_count(cnt[0]), .last_strike(ls[0]),
    .last_ball(lb[0]), .attempts(att[0]), .dup_err(dup[0]), .won(wn[0]),
    .lost(lo[0])
  );

  round_controller #(.MAX_ATTEMPTS(2), .ATT_W(4), .RESULT_LAT(3)) u_dut1 (
    .clk(clk), .rst(rst), .digit_valid(dv[1]), .digit(dg[1]), .del(dl[1]),
    .new_game(ng[1]), .strike(stk[1]), .ball(bal[1]), .guess(gs[1]),
    .check_en(ce[1]), .digit_count(cnt[1]), .last_strike(ls[1]),
    .last_ball(lb[1]), .attempts(att[1]), .dup_err(dup[1]), .won(wn[1]),
    .lost(lo[1])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv)
    else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic key(input int i, input logic [3:0] d);
    dv[i] = 1'b1;
    dg[i] = d;
    tick();
    dv[i] = 1'b0;
  endtask

  task automatic delete(input int i);
    dl[i] = 1'b1;
    tick();
    dl[i] = 1'b0;
  endtask

  task automatic restart_game(input int i);
    ng[i] = 1'b1;
    tick();
    ng[i] = 1'b0;
  endtask

  // Scoreboard: each check_en pulse must carry the queued guess and last one cycle.
  always @(negedge clk) begin
    if (ce[0]) begin
      chk("ce0_single", {31'd0, prev_ce[0]}, 32'd0);
      if (exp_q0.size() == 0) chk("ce0_unexpected", 32'd1, 32'd0);
      else chk("sb0_guess", {16'd0, gs[0]}, {16'd0, exp_q0.pop_front()});
    end
    if (ce[1]) begin
      chk("ce1_single", {31'd0, prev_ce[1]}, 32'd0);
      if (exp_q1.size() == 0) chk("ce1_unexpected", 32'd1, 32'd0);
      else chk("sb1_guess", {16'd0, gs[1]}, {16'd0, exp_q1.pop_front()});
    end
    prev_ce[0] <= ce[0];
    prev_ce[1] <= ce[1];
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b1;
    for (int i = 0; i < 2; i++) begin
      dv[i] = 1'b0; dg[i] = 4'd0; dl[i] = 1'b0; ng[i] = 1'b0;
      stk[i] = 4'd0; bal[i] = 4'd0; prev_ce[i] = 1'b0;
    end
    tick();
    tick();
    rst = 1'b0;

    // Reset state
    chk("rst_guess", {16'd0, gs[0]}, 32'h0000FFFF);
    chk("rst_count", {29'd0, cnt[0]}, 32'd0);
    chk("rst_att",   {28'd0, att[0]}, 32'd0);
    chk("rst_flags", {27'd0, ce[0], dup[0], wn[0], lo[0], 1'b0}, 32'd0);
    chk("rst_last",  {24'd0, ls[0], lb[0]}, 32'd0);
    chk("rst_guess1", {16'd0, gs[1]}, 32'h0000FFFF);

    // Winning guess 1,2,3,4 with scorer strike=4
    stk[0] = 4'd4;
    key(0, 4'd1);
    key(0, 4'd2);
    key(0, 4'd3);
    chk("part_guess", {16'd0, gs[0]}, 32'h0000F123);
    exp_q0.push_back(16'h1234);
    key(0, 4'd4);
    chk("win_ce_rise", {31'd0, ce[0]}, 32'd1);
    chk("win_count", {29'd0, cnt[0]}, 32'd4);
    tick();
    chk("win_ce_fall", {31'd0, ce[0]}, 32'd0);
    tick();
    chk("win_won", {31'd0, wn[0]}, 32'd1);
    chk("win_att", {28'd0, att[0]}, 32'd1);
    chk("win_strike", {28'd0, ls[0]}, 32'd4);
    key(0, 4'd5);
    chk("won_ignores_key", {16'd0, gs[0]}, 32'h00001234);
    chk("won_held", {31'd0, wn[0]}, 32'd1);
    restart_game(0);
    chk("ng_guess", {16'd0, gs[0]}, 32'h0000FFFF);
    chk("ng_won", {31'd0, wn[0]}, 32'd0);
    chk("ng_att", {28'd0, att[0]}, 32'd0);

    // Duplicate rejection
    key(0, 4'd1);
    key(0, 4'd1);
    chk("dup_pulse", {31'd0, dup[0]}, 32'd1);
    chk("dup_guess", {16'd0, gs[0]}, 32'h0000FFF1);
    chk("dup_count", {29'd0, cnt[0]}, 32'd1);
    tick();
    chk("dup_clear", {31'd0, dup[0]}, 32'd0);
    key(0, 4'd12);
    chk("range_ignored", {16'd0, gs[0]}, 32'h0000FFF1);

    // Delete, and delete winning over a simultaneous digit
    restart_game(0);
    key(0, 4'd5);
    key(0, 4'd6);
    delete(0);
    chk("del_guess", {16'd0, gs[0]}, 32'h0000FFF5);
    key(0, 4'd7);
    chk("del_then_key", {16'd0, gs[0]}, 32'h0000FF57);
    dl[0] = 1'b1;
    key(0, 4'd8);
    dl[0] = 1'b0;
    chk("del_wins_guess", {16'd0, gs[0]}, 32'h0000FFF5);
    chk("del_wins_count", {29'd0, cnt[0]}, 32'd1);
    restart_game(0);

    // Instance 1: result latency of 3, earlier scorer values must not be sampled
    stk[1] = 4'd4;
    bal[1] = 4'd0;
    key(1, 4'd1);
    key(1, 4'd2);
    key(1, 4'd3);
    exp_q1.push_back(16'h1234);
    key(1, 4'd4);
    chk("lat_ce_rise", {31'd0, ce[1]}, 32'd1);
    tick();
    tick();
    tick();
    chk("lat_not_yet", {24'd0, ls[1], att[1]}, 32'd0);
    stk[1] = 4'd1;
    bal[1] = 4'd2;
    tick();
    stk[1] = 4'd4;
    chk("lat_strike", {28'd0, ls[1]}, 32'd1);
    chk("lat_ball", {28'd0, lb[1]}, 32'd2);
    chk("lat_att", {28'd0, att[1]}, 32'd1);
    chk("lat_show", {30'd0, wn[1], lo[1]}, 32'd0);
    chk("show_guess", {16'd0, gs[1]}, 32'h00001234);

    // Second guess from SHOW exhausts attempts
    stk[1] = 4'd1;
    key(1, 4'd5);
    chk("show_restart", {16'd0, gs[1]}, 32'h0000FFF5);
    chk("show_count", {29'd0, cnt[1]}, 32'd1);
    key(1, 4'd6);
    key(1, 4'd7);
    exp_q1.push_back(16'h5678);
    key(1, 4'd8);
    tick();
    tick();
    tick();
    tick();
    chk("lost_flag", {31'd0, lo[1]}, 32'd1);
    chk("lost_att", {28'd0, att[1]}, 32'd2);
    chk("lost_last", {24'd0, ls[1], lb[1]}, 32'h00000012);
    key(1, 4'd9);
    chk("lost_ignores", {16'd0, gs[1]}, 32'h00005678);
    chk("lost_held", {31'd0, lo[1]}, 32'd1);

    // new_game during WAIT cancels the in-flight check
    restart_game(1);
    chk("ng_lost", {30'd0, wn[1], lo[1]}, 32'd0);
    key(1, 4'd1);
    key(1, 4'd2);
    key(1, 4'd3);
    exp_q1.push_back(16'h1234);
    key(1, 4'd4);
    tick();
    restart_game(1);
    chk("ngw_guess", {16'd0, gs[1]}, 32'h0000FFFF);
    chk("ngw_att", {28'd0, att[1]}, 32'd0);
    chk("ngw_count", {29'd0, cnt[1]}, 32'd0);
    for (int k = 0; k < 5; k++) tick();
    chk("ngw_att_later", {28'd0, att[1]}, 32'd0);
    chk("ngw_flags", {30'd0, wn[1], lo[1]}, 32'd0);

    chk("sb0_drained", exp_q0.size(), 32'd0);
    chk("sb1_drained", exp_q1.size(), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
